// File: rtl/clock_mode_ctrl_if.sv
// Front-panel / timekeeper bundle for clock_mode_ctrl.
// The slave modport is the controller; the master modport is its environment
// (keys, prescaler strobe and timekeeper).
//
// Signalling rules: there is no valid/ready pairing on this bundle. Every
// strobe (sample_tick in, load out) is a single-cycle pulse that the receiver
// must accept in the cycle it is high. The receiver never stalls it. All
// other signals are levels that are sampled on every rising clock edge.
interface clock_mode_ctrl_if;
    logic        key_mode;
    logic        key_add;
    logic        sample_tick;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic        run_en;
    logic        load;
    logic [4:0]  load_hour;
    logic [5:0]  load_minute;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [1:0]  mode;

    modport slave (
        input  key_mode, key_add, sample_tick, hour, minute, second,
        output run_en, load, load_hour, load_minute, digits, blank, mode
    );

    modport master (
        output key_mode, key_add, sample_tick, hour, minute, second,
        input  run_en, load, load_hour, load_minute, digits, blank, mode
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode and time-setting controller for the digital clock.
// Debounces the mode/add keys, runs the SHOW_HM/SHOW_MS/SET_MIN/SET_HOUR state
// machine, freezes and reloads the timekeeper and drives four BCD digits plus
// a per-digit blank mask. The FSM state is visible on the mode output.
// Optional feature macro: CLOCK_MODE_AUTOREPEAT_EN (add-key auto-repeat in the
// set states). Without it each physical add press gives one increment.
module clock_mode_ctrl #(
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int BLINK_SAMPLES    = 16,
    parameter int REPEAT_DELAY     = 32,
    parameter int REPEAT_RATE      = 8
) (
    input logic              clock,
    input logic              reset,
    clock_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        SHOW_HM  = 2'd0,
        SHOW_MS  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } mode_t;

    localparam logic [3:0] DB_LIMIT    = 4'(DEBOUNCE_SAMPLES);
    localparam logic [7:0] BLINK_LIMIT = 8'(BLINK_SAMPLES);

    // Index 0 is the mode key, index 1 is the add key.
    logic [1:0] raw_key;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [3:0] db_cnt [2];

    mode_t      state;
    logic       run_en_q;
    logic       load_q;
    logic [4:0] load_hour_q;
    logic [5:0] load_minute_q;
    logic [4:0] e_hour;
    logic [5:0] e_min;
    logic       blink;
    logic [7:0] blink_cnt;
    logic       rep_press;
    logic       mode_evt;
    logic       add_evt;
    logic       in_set;

    assign raw_key = {bus.key_add, bus.key_mode};
    assign in_set  = state[1];

    // Splits a 0..59 value into tens/units BCD nibbles.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 6'd10);
        units = 4'(v % 6'd10);
        return {tens, units};
    endfunction

    // Per-key debounce on sample_tick; a 0->1 acceptance emits a one-cycle press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_level <= '0;
            key_press <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            key_press <= '0;
            if (bus.sample_tick) begin
                for (int k = 0; k < 2; k++) begin
                    if (raw_key[k] == key_level[k]) begin
                        db_cnt[k] <= '0;
                    end else if (db_cnt[k] + 4'd1 == DB_LIMIT) begin
                        db_cnt[k]    <= '0;
                        key_level[k] <= raw_key[k];
                        key_press[k] <= raw_key[k];
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 4'd1;
                    end
                end
            end
        end
    end

`ifdef CLOCK_MODE_AUTOREPEAT_EN
    localparam logic [7:0] REP_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] REP_RATE  = 8'(REPEAT_RATE);

    logic [7:0] rep_cnt;
    logic       rep_armed;

    // Counts held samples after a press; fires after REPEAT_DELAY, then every REPEAT_RATE.
    // Counting only while the raw key is still high stops repeats during the release debounce.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_press <= 1'b0;
        end else begin
            rep_press <= 1'b0;
            if (!in_set || !key_level[1] || key_press[1] || key_press[0]) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (bus.sample_tick && raw_key[1]) begin
                if (rep_cnt + 8'd1 == (rep_armed ? REP_RATE : REP_DELAY)) begin
                    rep_cnt   <= '0;
                    rep_armed <= 1'b1;
                    rep_press <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 8'd1;
                end
            end
        end
    end
`else
    // No auto-repeat: the expression folds to 0 for any legal parameter value,
    // keeping the repeat parameters referenced for drop-in compatibility.
    assign rep_press = (REPEAT_DELAY < 0) || (REPEAT_RATE < 0);
`endif

    // Mode beats add when both pulse in the same cycle.
    assign mode_evt = key_press[0];
    assign add_evt  = key_press[1] | rep_press;

    // Mode FSM with edit registers, timekeeper control and blink phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= SHOW_HM;
            run_en_q      <= 1'b1;
            load_q        <= 1'b0;
            load_hour_q   <= '0;
            load_minute_q <= '0;
            e_hour        <= '0;
            e_min         <= '0;
            blink         <= 1'b0;
            blink_cnt     <= '0;
        end else begin
            load_q <= 1'b0;
            if (mode_evt) begin
                case (state)
                    SHOW_HM: state <= SHOW_MS;
                    SHOW_MS: begin
                        state     <= SET_MIN;
                        e_hour    <= bus.hour;
                        e_min     <= bus.minute;
                        run_en_q  <= 1'b0;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end
                    SET_MIN: state <= SET_HOUR;
                    default: begin
                        state         <= SHOW_HM;
                        load_q        <= 1'b1;
                        load_hour_q   <= e_hour;
                        load_minute_q <= e_min;
                        run_en_q      <= 1'b1;
                        blink         <= 1'b0;
                        blink_cnt     <= '0;
                    end
                endcase
            end else if (add_evt && in_set) begin
                if (state == SET_MIN) begin
                    e_min <= (e_min == 6'd59) ? 6'd0 : e_min + 6'd1;
                end else begin
                    e_hour <= (e_hour == 5'd23) ? 5'd0 : e_hour + 5'd1;
                end
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (in_set && bus.sample_tick) begin
                if (blink_cnt + 8'd1 == BLINK_LIMIT) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    // Registered display: digit selection and blink mask follow the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.digits <= '0;
            bus.blank  <= '0;
        end else begin
            case (state)
                SHOW_MS: begin
                    bus.digits <= {to_bcd(bus.minute), to_bcd(bus.second)};
                    bus.blank  <= 4'b0000;
                end
                SET_MIN: begin
                    bus.digits <= {to_bcd({1'b0, e_hour}), to_bcd(e_min)};
                    bus.blank  <= blink ? 4'b0011 : 4'b0000;
                end
                SET_HOUR: begin
                    bus.digits <= {to_bcd({1'b0, e_hour}), to_bcd(e_min)};
                    bus.blank  <= blink ? 4'b1100 : 4'b0000;
                end
                default: begin
                    bus.digits <= {to_bcd({1'b0, bus.hour}), to_bcd(bus.minute)};
                    bus.blank  <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.mode        = state;
    assign bus.run_en      = run_en_q;
    assign bus.load        = load_q;
    assign bus.load_hour   = load_hour_q;
    assign bus.load_minute = load_minute_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: reset, debounce, mode cycling, editing
// with wrap, blink mask, load pulse, mode/add collision, held add key and
// reset in the middle of an edit.
module tb_clock_mode_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef CLOCK_MODE_AUTOREPEAT_EN
    localparam logic [5:0] HELD_MIN = 6'd15;
    localparam logic [7:0] HELD_BCD = 8'h15;
`else
    localparam logic [5:0] HELD_MIN = 6'd11;
    localparam logic [7:0] HELD_BCD = 8'h11;
`endif

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Driver tasks
    task automatic sample();
        @(negedge clock) bus.sample_tick = 1'b1;
        @(negedge clock) bus.sample_tick = 1'b0;
    endtask

    task automatic samples(input int n);
        repeat (n) sample();
    endtask

    task automatic press_key(input bit is_add);
        if (is_add) bus.key_add = 1'b1;
        else        bus.key_mode = 1'b1;
        samples(4);
        repeat (3) @(negedge clock);
        bus.key_add  = 1'b0;
        bus.key_mode = 1'b0;
        samples(4);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b0;
        bus.key_mode     = 1'b0;
        bus.key_add      = 1'b0;
        bus.sample_tick  = 1'b0;
        bus.hour         = 5'd13;
        bus.minute       = 6'd7;
        bus.second       = 6'd42;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_run_en", 32'(bus.run_en), 32'd1);
        check("rst_load", 32'(bus.load), 32'd0);
        check("rst_digits", 32'(bus.digits), 32'h0000);
        check("rst_blank", 32'(bus.blank), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_digits", 32'(bus.digits), 32'h1307);
        check("idle_mode", 32'(bus.mode), 32'd0);

        // Add is ignored in SHOW_HM
        press_key(1'b1);
        check("add_show_mode", 32'(bus.mode), 32'd0);
        check("add_show_digits", 32'(bus.digits), 32'h1307);

        // Bouncing mode key: 1-0-1 then held; flip on the 4th consecutive high sample
        bus.key_mode = 1'b1; sample();
        bus.key_mode = 1'b0; sample();
        bus.key_mode = 1'b1; sample();
        samples(2);
        repeat (2) @(negedge clock);
        check("bounce_3_mode", 32'(bus.mode), 32'd0);
        sample();
        check("pulse_cycle_mode", 32'(bus.mode), 32'd0);
        @(negedge clock);
        check("bounce_mode", 32'(bus.mode), 32'd1);
        @(negedge clock);
        check("show_ms_digits", 32'(bus.digits), 32'h0742);
        bus.key_mode = 1'b0;
        samples(4);
        repeat (2) @(negedge clock);
        check("release_mode", 32'(bus.mode), 32'd1);

        // Enter SET_MIN at 23:59 and edit the minute
        bus.hour   = 5'd23;
        bus.minute = 6'd59;
        bus.second = 6'd5;
        repeat (2) @(negedge clock);
        check("show_ms_live", 32'(bus.digits), 32'h5905);
        press_key(1'b0);
        check("set_min_mode", 32'(bus.mode), 32'd2);
        check("set_min_run", 32'(bus.run_en), 32'd0);
        check("set_min_digits", 32'(bus.digits), 32'h2359);
        bus.minute = 6'd30;
        press_key(1'b1);
        check("min_wrap_digits", 32'(bus.digits), 32'h2300);
        check("min_wrap_run", 32'(bus.run_en), 32'd0);
        press_key(1'b1);
        check("min_inc_digits", 32'(bus.digits), 32'h2301);

        // Blink: 4 samples since the last add, 11 more keep phase 0, the 16th toggles
        samples(11);
        check("blink_off", 32'(bus.blank), 32'b0000);
        sample();
        @(negedge clock);
        check("blink_min", 32'(bus.blank), 32'b0011);

        // SET_HOUR keeps the phase; add wraps 23 -> 0 and clears the phase
        press_key(1'b0);
        check("set_hour_mode", 32'(bus.mode), 32'd3);
        check("blink_hour", 32'(bus.blank), 32'b1100);
        check("set_hour_digits", 32'(bus.digits), 32'h2301);
        press_key(1'b1);
        check("hour_wrap_digits", 32'(bus.digits), 32'h0001);
        check("hour_wrap_blank", 32'(bus.blank), 32'b0000);
        check("hour_run", 32'(bus.run_en), 32'd0);

        // Mode press leaves SET_HOUR with a single-cycle load
        bus.key_mode = 1'b1;
        samples(4);
        check("load_pre", 32'(bus.load), 32'd0);
        check("load_pre_mode", 32'(bus.mode), 32'd3);
        @(negedge clock);
        check("load_pulse", 32'(bus.load), 32'd1);
        check("load_mode", 32'(bus.mode), 32'd0);
        check("load_run", 32'(bus.run_en), 32'd1);
        check("load_hour", 32'(bus.load_hour), 32'd0);
        check("load_minute", 32'(bus.load_minute), 32'd1);
        @(negedge clock);
        check("load_end", 32'(bus.load), 32'd0);
        bus.key_mode = 1'b0;
        samples(4);
        repeat (2) @(negedge clock);
        check("after_load_digits", 32'(bus.digits), 32'h2330);
        check("load_minute_hold", 32'(bus.load_minute), 32'd1);

        // Mode and add accepted in the same cycle in SET_MIN: mode wins
        bus.hour   = 5'd9;
        bus.minute = 6'd45;
        press_key(1'b0);
        press_key(1'b0);
        check("collide_pre_digits", 32'(bus.digits), 32'h0945);
        bus.key_mode = 1'b1;
        bus.key_add  = 1'b1;
        samples(4);
        repeat (3) @(negedge clock);
        bus.key_mode = 1'b0;
        bus.key_add  = 1'b0;
        samples(4);
        repeat (2) @(negedge clock);
        check("collide_mode", 32'(bus.mode), 32'd3);
        check("collide_digits", 32'(bus.digits), 32'h0945);
        press_key(1'b0);
        check("collide_load_hour", 32'(bus.load_hour), 32'd9);
        check("collide_load_min", 32'(bus.load_minute), 32'd45);

        // Add held for 64 samples in SET_MIN from 10
        bus.hour   = 5'd5;
        bus.minute = 6'd10;
        press_key(1'b0);
        press_key(1'b0);
        bus.key_add = 1'b1;
        samples(64);
        bus.key_add = 1'b0;
        samples(4);
        repeat (2) @(negedge clock);
        check("held_digits", 32'(bus.digits), 32'({8'h05, HELD_BCD}));
        press_key(1'b0);
        press_key(1'b0);
        check("held_load_min", 32'(bus.load_minute), 32'(HELD_MIN));
        check("held_load_hour", 32'(bus.load_hour), 32'd5);

        // Reset in the middle of an edit
        press_key(1'b0);
        press_key(1'b0);
        check("pre_reset_run", 32'(bus.run_en), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_mode", 32'(bus.mode), 32'd0);
        check("mid_rst_run", 32'(bus.run_en), 32'd1);
        check("mid_rst_load", 32'(bus.load), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_mode", 32'(bus.mode), 32'd0);
        check("post_rst_load", 32'(bus.load), 32'd0);
        check("post_rst_digits", 32'(bus.digits), 32'h0510);
        check("post_rst_load_min", 32'(bus.load_minute), 32'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
